// File: rtl/port_rd_xfer.sv
// Read-transfer engine for one output port: walks a packet descriptor as
// sequential SRAM reads and tags the returned words with SOP/valid/EOP.
module port_rd_xfer #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_vld,
  output logic              pkt_rdy,
  input  logic [ADDR_W-1:0] pkt_addr,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              xfer_pause,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [15:0]       sram_rd_data,
  output logic              xfer_data_vld,
  output logic [15:0]       xfer_data,
  output logic              end_of_packet,
  output logic              ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  left;
  logic              first;
  logic              last_rd;

  assign pkt_rdy      = (state == IDLE);
  assign sram_rd_en   = (state == READ) & ~xfer_pause;
  assign sram_rd_addr = cur_addr;
  assign xfer_data    = sram_rd_data;
  assign last_rd      = (left == LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pkt_vld && pkt_len != '0) state_nxt = READ;
      READ:    if (sram_rd_en && last_rd)    state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      left          <= '0;
      first         <= 1'b0;
      xfer_data_vld <= 1'b0;
      ready         <= 1'b0;
      end_of_packet <= 1'b0;
    end else begin
      state <= state_nxt;
      // A zero-length descriptor still loads, but never leaves IDLE.
      if (state == IDLE && pkt_vld) begin
        cur_addr <= pkt_addr;
        left     <= pkt_len;
        first    <= 1'b1;
      end else if (sram_rd_en) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        left     <= left - LEN_W'(1);
        first    <= 1'b0;
      end
      // Strobes track the SRAM's one-cycle read latency.
      xfer_data_vld <= sram_rd_en;
      ready         <= sram_rd_en & first;
      end_of_packet <= sram_rd_en & last_rd;
    end
  end

endmodule

// File: tb/tb_port_rd_xfer.sv
// Bench for port_rd_xfer: vector table, hand sequences and random traffic
// against a queue-based read/word scoreboard.
module tb_port_rd_xfer;
  localparam int AW = 14;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_vld = 1'b0;
  logic          pkt_rdy;
  logic [AW-1:0] pkt_addr = '0;
  logic [LW-1:0] pkt_len = '0;
  logic          xfer_pause = 1'b0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [15:0]   sram_rd_data = '0;
  logic          xfer_data_vld;
  logic [15:0]   xfer_data;
  logic          end_of_packet;
  logic          ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  port_rd_xfer #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .xfer_pause(xfer_pause),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .xfer_data_vld(xfer_data_vld),
    .xfer_data(xfer_data), .end_of_packet(end_of_packet), .ready(ready)
  );

  function automatic logic [15:0] mem(input logic [AW-1:0] a);
    return {a[7:0], 2'b10, a[13:8]} ^ 16'hC35A;
  endfunction

  // SRAM: data one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    sram_rd_data <= sram_rd_en ? mem(sram_rd_addr) : 16'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: queue of reads still owed, plus the word due this cycle.
  typedef struct {logic [AW-1:0] addr; bit first; bit last;} rd_t;
  rd_t         q[$];
  bit          drain = 0, pv = 0, pf = 0, pl = 0;
  logic [15:0] pd = '0;

  initial begin
    bit en, rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_rdy", 32'(pkt_rdy), 1);
        check("rst_en", 32'(sram_rd_en), 0);
        check("rst_addr", 32'(sram_rd_addr), 0);
        check("rst_out", 32'({xfer_data_vld, ready, end_of_packet}), 0);
        check("pass_data", 32'(xfer_data), 32'(sram_rd_data));
        q.delete(); drain = 0; pv = 0;
      end else begin
        en  = (q.size() > 0) && !xfer_pause;
        rdy = (q.size() == 0) && !drain;
        check("rd_en", 32'(sram_rd_en), 32'(en));
        if (en) check("rd_addr", 32'(sram_rd_addr), 32'(q[0].addr));
        check("pkt_rdy", 32'(pkt_rdy), 32'(rdy));
        check("data_vld", 32'(xfer_data_vld), 32'(pv));
        check("ready", 32'(ready), 32'(pv & pf));
        check("eop", 32'(end_of_packet), 32'(pv & pl));
        if (pv) check("data", 32'(xfer_data), 32'(pd));
        pv = en; drain = 0;
        if (en) begin
          pf = q[0].first; pl = q[0].last; pd = mem(q[0].addr); drain = q[0].last;
          void'(q.pop_front());
        end
        if (rdy && pkt_vld && pkt_len != '0)
          for (int i = 0; i < int'(pkt_len); i++)
            q.push_back('{addr: pkt_addr + AW'(i), first: (i == 0), last: (i == int'(pkt_len) - 1)});
      end
    end
  end

  typedef struct {logic [AW-1:0] addr; int len; int ps; int pn;
                  int e_first; int e_ready; int e_eop; int e_rdy;} vec_t;

  // k counts cycles after the acceptance edge (k=1 is the first READ cycle).
  task automatic run_vec(input vec_t v, input string tag);
    int first_k = 0, ready_k = 0, eop_k = 0, rdy_k = 0, nw = 0, nr = 0, ne = 0;
    @(posedge clk); #1;
    pkt_vld = 1; pkt_addr = v.addr; pkt_len = LW'(v.len);
    @(posedge clk); #1;
    pkt_vld = 0;
    for (int k = 1; k <= v.len + v.pn + 4; k++) begin
      xfer_pause = (v.pn > 0) && (k >= v.ps) && (k < v.ps + v.pn);
      @(negedge clk);
      if (sram_rd_en && first_k == 0) first_k = k;
      if (xfer_data_vld) nw++;
      if (ready) begin nr++; if (ready_k == 0) ready_k = k; end
      if (end_of_packet) begin ne++; eop_k = k; end
      if (pkt_rdy && rdy_k == 0) rdy_k = k;
      @(posedge clk); #1;
    end
    xfer_pause = 0;
    check({tag, ".first_rd"}, first_k, v.e_first);
    check({tag, ".ready_cyc"}, ready_k, v.e_ready);
    check({tag, ".eop_cyc"}, eop_k, v.e_eop);
    check({tag, ".rdy_cyc"}, rdy_k, v.e_rdy);
    check({tag, ".words"}, nw, v.len);
    check({tag, ".n_ready"}, nr, (v.len > 0) ? 1 : 0);
    check({tag, ".n_eop"}, ne, (v.len > 0) ? 1 : 0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t fresh;
    int acc_k, nw, nr, ne, r0, r1, e0, e1;
    vecs[0] = '{14'h0100,    4, 0, 0, 1, 2,    5,    6};
    vecs[1] = '{14'h3FFF,    1, 0, 0, 1, 2,    2,    3};
    vecs[2] = '{14'h0055,    0, 0, 0, 0, 0,    0,    1};
    vecs[3] = '{14'h0200,    3, 2, 2, 1, 2,    6,    7};
    vecs[4] = '{14'h1234,    7, 3, 1, 1, 2,    9,   10};
    vecs[5] = '{14'h3FFE,    3, 0, 0, 1, 2,    4,    5};
    vecs[6] = '{14'h3F00, 1023, 0, 0, 1, 2, 1024, 1025};
    fresh   = '{14'h0C00,    2, 0, 0, 1, 2,    3,    4};

    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        @(negedge clk);
        check("wrap_addr", 32'(sram_rd_addr), 0);
      end
    end

    // Async reset while word 2 of an 8-word packet is on the bus.
    @(posedge clk); #1;
    pkt_vld = 1; pkt_addr = 14'h0800; pkt_len = 10'd8;
    @(posedge clk); #1;
    pkt_vld = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_vld_before", 32'(xfer_data_vld), 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_out", 32'({xfer_data_vld, ready, end_of_packet}), 0);
    check("mid_rst_en", 32'(sram_rd_en), 0);
    check("mid_rst_rdy", 32'(pkt_rdy), 1);
    @(posedge clk); #1 rst_n = 1;
    run_vec(fresh, "post_rst");

    // Back-to-back: pkt_vld held, len=2 then len=3.
    @(posedge clk); #1;
    pkt_vld = 1; pkt_addr = 14'h0A00; pkt_len = 10'd2;
    @(posedge clk); #1;
    pkt_addr = 14'h0B00; pkt_len = 10'd3;
    acc_k = 0; nw = 0; nr = 0; ne = 0; r0 = 0; r1 = 0; e0 = 0; e1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pkt_rdy && pkt_vld && acc_k == 0) acc_k = k;
      if (xfer_data_vld) nw++;
      if (ready) begin nr++; if (r0 == 0) r0 = k; else r1 = k; end
      if (end_of_packet) begin ne++; if (e0 == 0) e0 = k; else e1 = k; end
      @(posedge clk); #1;
      if (acc_k == k) pkt_vld = 0;
    end
    pkt_vld = 0;
    check("b2b.accept", acc_k, 4);
    check("b2b.words", nw, 5);
    check("b2b.n_ready", nr, 2);
    check("b2b.n_eop", ne, 2);
    check("b2b.ready0", r0, 2);
    check("b2b.eop0", e0, 3);
    check("b2b.ready1", r1, 6);
    check("b2b.eop1", e1, 8);

    // Random traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      pkt_vld    = ($urandom_range(0, 2) == 0);
      pkt_addr   = ($urandom_range(0, 3) == 0) ? AW'(14'h3FF8 + $urandom_range(0, 7)) : AW'($urandom);
      pkt_len    = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 12));
      xfer_pause = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    pkt_vld = 0; xfer_pause = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("end_idle", 32'(pkt_rdy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_rd_xfer.md
# port_rd_xfer

Read-transfer engine for one output port. It takes a packet descriptor (first SRAM word address and length), issues sequential 16-bit SRAM reads, and presents the returned words to the port read frontend. It drives the frontend's `xfer_data_vld`, `xfer_data`, `end_of_packet` and `ready` inputs, so the frontend's registered `rd_sop`, `rd_vld` and `rd_eop` line up on the first and last word of each packet.

## Interface
- `ADDR_W`, 14, SRAM word-address width.
- `LEN_W`, 10, packet-length width in 16-bit words; maximum length is 2^LEN_W-1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `pkt_vld`  in  1  descriptor valid.
- `pkt_rdy`  out  1  engine idle and accepts a descriptor; equals (state==IDLE).
- `pkt_addr`  in  ADDR_W  first word address.
- `pkt_len`  in  LEN_W  word count, 0..2^LEN_W-1.
- `xfer_pause`  in  1  scheduler hold; blocks issue of new SRAM reads.
- `sram_rd_en`  out  1  SRAM read strobe; equals (state==READ) & ~xfer_pause.
- `sram_rd_addr`  out  ADDR_W  read address; equals the `cur_addr` register.
- `sram_rd_data`  in  16  read data; valid exactly 1 cycle after `sram_rd_en`.
- `xfer_data_vld`  out  1  `xfer_data` carries a packet word this cycle.
- `xfer_data`  out  16  combinational pass-through of `sram_rd_data`.
- `end_of_packet`  out  1  current word is the last word of the packet.
- `ready`  out  1  current word is the first word of the packet; drives frontend SOP.

## Operation
- FSM states: IDLE, READ, DRAIN.
- Registers: `cur_addr`[ADDR_W], `left`[LEN_W], `first`.
- Registers: `xfer_data_vld`, `ready`, `end_of_packet` (delayed strobes).
- IDLE:
  - On `pkt_vld`: load `cur_addr`<=`pkt_addr`, `left`<=`pkt_len`, `first`<=1.
  - If `pkt_len`==0, the descriptor is consumed, the engine stays in IDLE and produces no output.
  - Otherwise go to READ.
- READ, each cycle with `sram_rd_en`=1:
  - `cur_addr`<=`cur_addr`+1, modulo 2^ADDR_W; it wraps from 2^ADDR_W-1 to 0.
  - `left`<=`left`-1 and `first`<=0.
  - Next cycle: `xfer_data_vld`<=1, `ready`<=`first`, `end_of_packet`<=(`left`==1).
  - When `left`==1, go to DRAIN.
- READ with `xfer_pause`=1: no read is issued and all registers hold. Next cycle `xfer_data_vld`, `ready` and `end_of_packet` are 0, which leaves a bubble in the word stream.
- DRAIN: the last word emerges this cycle; go to IDLE next cycle. `xfer_pause` has no effect here.
- In any cycle without a read in the prior cycle, `xfer_data_vld`, `ready` and `end_of_packet` are 0.
- A single-word packet asserts `ready`, `xfer_data_vld` and `end_of_packet` in the same cycle.
- Exactly one `ready` and one `end_of_packet` occur per non-zero packet, regardless of pauses.
- `pkt_vld` while `pkt_rdy`=0 is ignored. The upstream holds the descriptor until `pkt_rdy`=1.

## Timing
- Reset values:
  - State IDLE, so `pkt_rdy`=1.
  - `sram_rd_en`=0; `sram_rd_addr`=0 (`cur_addr`=0).
  - `left`=0, `first`=0.
  - `xfer_data_vld`=0, `ready`=0, `end_of_packet`=0.
  - `xfer_data` follows `sram_rd_data` at all times.
- Reset mid-packet: all state clears immediately. Reads still in flight in the SRAM are not flagged valid. No `end_of_packet` is produced for the aborted packet.
- Descriptor accepted at edge T, no pauses, length L≥1:
  - Reads issue in cycles T+1..T+L.
  - Words appear in cycles T+2..T+L+1: `ready` at T+2, `end_of_packet` at T+L+1.
  - DRAIN is at T+L+1; `pkt_rdy` returns to 1 at T+L+2.
  - Minimum descriptor spacing is L+2 cycles.
- Each pause cycle in READ adds exactly one cycle to every later event of that packet.
- Read latency, `sram_rd_en` to `xfer_data_vld`: exactly 1 cycle.

## Test plan
- Reset release, then descriptor addr=0x0100, len=4, no pause:
  - `sram_rd_en` is high in cycles 1-4 with addresses 0x100-0x103.
  - `xfer_data_vld` is high in cycles 2-5; `ready` only in cycle 2; `end_of_packet` only in cycle 5.
  - `pkt_rdy`=1 in cycle 6.
- len=1, addr=0x3FFF: one read at 0x3FFF. `ready`, `xfer_data_vld` and `end_of_packet` are all high in the same cycle. `cur_addr` wraps to 0x0000.
- len=0: the descriptor is consumed. No `sram_rd_en`, no valid word, and `pkt_rdy` stays 1.
- len=3 with `xfer_pause` high for 2 cycles after the first read:
  - Addresses are still consecutive.
  - There is a 2-cycle `xfer_data_vld` gap.
  - `ready` and `end_of_packet` each occur exactly once, and `end_of_packet` is 2 cycles later than in the unpaused case.
- `rst_n` asserted asynchronously mid-packet at word 2 of len=8:
  - All outputs go to 0 immediately and `pkt_rdy`=1.
  - A fresh len=2 descriptor then completes normally.
- Back-to-back descriptors len=2 and len=3, `pkt_vld` held high:
  - The second descriptor is accepted exactly 4 cycles after the first.
  - The word streams do not overlap, and each has one `ready` and one `end_of_packet`.
